// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: multi-channel H-bridge PWM driver with a dead-time
// interlock on reversal, plus a 4x quadrature encoder interface per channel
// giving a wrapping position count and a periodic velocity sample.
module motor_drive_ctrl #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEAD_CYC   = 64,
    parameter int unsigned VEL_PERIOD = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_CH*(PWM_W+1)-1:0] duty_cmd,
    input  logic                      cmd_valid,
    input  logic [N_CH-1:0]           enc_a,
    input  logic [N_CH-1:0]           enc_b,
    input  logic [N_CH-1:0]           cnt_clr,
    output logic [N_CH-1:0]           pwm_en,
    output logic [N_CH-1:0]           in_a,
    output logic [N_CH-1:0]           in_b,
    output logic [N_CH*CNT_W-1:0]     enc_count,
    output logic [N_CH*CNT_W-1:0]     enc_vel,
    output logic                      vel_valid,
    output logic [N_CH-1:0]           enc_err
);
    localparam int unsigned DW = PWM_W + 1;
    localparam int unsigned TW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int unsigned VW = $clog2(VEL_PERIOD);
    localparam logic [PWM_W-1:0] PWM_LAST  = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [TW-1:0]    DEAD_LOAD = TW'(DEAD_CYC - 1);
    localparam logic [VW-1:0]    VEL_LAST  = VW'(VEL_PERIOD - 1);

    typedef enum logic [1:0] {STOP, FWD, REV, DEAD} dir_t;

    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_wrap;
    logic [VW-1:0]    vel_cnt;
    logic             vel_tc;

    assign pwm_wrap = (pwm_cnt == PWM_LAST);
    assign vel_tc   = (vel_cnt == VEL_LAST);

    // Shared PWM carrier: counts 0..2^PWM_W-2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pwm_cnt <= '0;
        else if (pwm_wrap) pwm_cnt <= '0;
        else               pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Shared velocity window counter and sample strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vel_cnt   <= '0;
            vel_valid <= 1'b0;
        end else begin
            vel_cnt   <= vel_tc ? '0 : vel_cnt + 1'b1;
            vel_valid <= vel_tc;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DW-1:0]    cmd, shadow, active;
        logic [PWM_W-1:0] mag;
        logic             raw;
        dir_t             state, target, nxt;
        logic [TW-1:0]    dead_cnt;
        logic             pwm_q, in_a_q, in_b_q;
        logic [1:0]       s1, s2, prv;
        logic             up, dn, bad;
        logic [CNT_W-1:0] count, snap, vel;
        logic             err;

        assign cmd = duty_cmd[i*DW +: DW];

        // Shadow takes every command; active only changes at the carrier wrap
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (cmd_valid) shadow <= cmd;
                if (pwm_wrap)  active <= cmd_valid ? cmd : shadow;
            end
        end

        // Magnitude (most-negative value clipped to full scale), raw PWM, target direction
        always_comb begin
            mag = active[PWM_W-1:0];
            if (active[PWM_W]) begin
                if (active[PWM_W-1:0] == '0) mag = '1;
                else                         mag = ~active[PWM_W-1:0] + 1'b1;
            end
            raw = (pwm_cnt < mag);
            if (active == '0)       target = STOP;
            else if (active[PWM_W]) target = REV;
            else                    target = FWD;
        end

        // Direction next-state: reversals always pass through DEAD
        always_comb begin
            nxt = state;
            if (!enable) nxt = STOP;
            else begin
                case (state)
                    STOP:    nxt = target;
                    FWD:     nxt = (target == REV) ? DEAD : target;
                    REV:     nxt = (target == FWD) ? DEAD : target;
                    DEAD:    nxt = (dead_cnt == '0) ? target : DEAD;
                    default: nxt = STOP;
                endcase
            end
        end

        // Direction FSM with outputs registered alongside the state
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= STOP;
                dead_cnt <= '0;
                pwm_q    <= 1'b0;
                in_a_q   <= 1'b0;
                in_b_q   <= 1'b0;
            end else begin
                state <= nxt;
                if (nxt == DEAD && state != DEAD)      dead_cnt <= DEAD_LOAD;
                else if (state == DEAD && dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
                in_a_q <= (nxt == FWD);
                in_b_q <= (nxt == REV);
                pwm_q  <= ((nxt == FWD) || (nxt == REV)) && raw;
            end
        end

        // Encoder synchroniser and previous-state register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1  <= '0;
                s2  <= '0;
                prv <= '0;
            end else begin
                s1  <= {enc_a[i], enc_b[i]};
                s2  <= s1;
                prv <= s2;
            end
        end

        // 4x decode of {A,B}: 00->10->11->01->00 counts up
        always_comb begin
            up  = 1'b0;
            dn  = 1'b0;
            bad = 1'b0;
            case ({prv, s2})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up  = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dn  = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
                default: ;
            endcase
        end

        // Position count, sticky error and velocity snapshot; clear wins over a step
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count <= '0;
                snap  <= '0;
                vel   <= '0;
                err   <= 1'b0;
            end else begin
                if (cnt_clr[i]) begin
                    count <= '0;
                    snap  <= '0;
                    err   <= 1'b0;
                end else begin
                    if (up)      count <= count + 1'b1;
                    else if (dn) count <= count - 1'b1;
                    if (bad)     err   <= 1'b1;
                    if (vel_tc)  snap  <= count;
                end
                if (vel_tc) vel <= count - snap;
            end
        end

        assign pwm_en[i]                  = pwm_q;
        assign in_a[i]                    = in_a_q;
        assign in_b[i]                    = in_b_q;
        assign enc_err[i]                 = err;
        assign enc_count[i*CNT_W +: CNT_W] = count;
        assign enc_vel[i*CNT_W +: CNT_W]   = vel;
    end

endmodule
